// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared constants and types for the load/store unit:
//   - MEM_RD_OP / MEM_WR_OP : the two opcodes the LSU acts on
//   - F3_*                  : func3 access size/sign encodings
//   - lsu_state_t           : LSU control state
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [6:0] MEM_RD_OP = 7'b0000011;
    localparam logic [6:0] MEM_WR_OP = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for the LSU.
//   Store path: is_store, st_offset, st_func3, store_data
//               -> be (byte enables), wdata (lane-replicated), misalign, illegal
//   Load path : ld_offset, ld_func3, rdata -> load_data (aligned + extended)
// Only WIDTH = 32 is supported.
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_store,
    input  logic [1:0]       st_offset,
    input  logic [2:0]       st_func3,
    input  logic [WIDTH-1:0] store_data,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata,
    output logic             misalign,
    output logic             illegal,
    input  logic [1:0]       ld_offset,
    input  logic [2:0]       ld_func3,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] load_data
);

    logic [WIDTH-1:0] shifted;

    // Request side: size comes from func3[1:0]; bit 2 only selects zero-extension.
    always_comb begin
        be       = 4'b0000;
        wdata    = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (st_func3[1:0])
            2'b00: begin
                be    = 4'b0001 << st_offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << st_offset;
                wdata    = {2{store_data[15:0]}};
                misalign = st_offset[0];
            end
            2'b10: begin
                be       = 4'b1111;
                wdata    = store_data;
                misalign = |st_offset;
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants exist only for byte/half loads.
        if (st_func3[2] && (is_store || st_func3[1])) begin
            illegal = 1'b1;
        end
    end

    // Response side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted   = rdata >> {ld_offset, 3'b000};
        load_data = '0;
        case (ld_func3)
            F3_B:    load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store stage behind the ALU. Accepts a load/store, issues one word-wide
// request on the data bus, stalls the PC until ack or timeout, then presents
// the extended load result (or an error pulse) for exactly one DONE cycle.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   valid, opcode, func3          instruction qualifiers
//   addr, store_data              effective address, rs2 value
//   stall                         hold PC/instruction
//   load_data, load_valid         extended load result, one-cycle valid
//   misalign_err, bus_err         one-cycle error pulses
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be             bus request fields (stable through WAIT)
//   mem_ack, mem_rdata            bus completion and read word
// -----------------------------------------------------------------------------
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             stall,
    output logic [WIDTH-1:0] load_data,
    output logic             load_valid,
    output logic             misalign_err,
    output logic             bus_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             is_load_q, is_load_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       func3_q, func3_d;
    logic [1:0]       off_q, off_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic             is_rd, is_wr, is_mem;
    logic [3:0]       lane_be;
    logic [WIDTH-1:0] lane_wdata;
    logic             lane_misalign, lane_illegal;
    logic [WIDTH-1:0] lane_load;

    assign is_rd  = (opcode == MEM_RD_OP);
    assign is_wr  = (opcode == MEM_WR_OP);
    assign is_mem = valid && (is_rd || is_wr);

    lsu_lane_align #(.WIDTH(WIDTH)) u_lane (
        .is_store   (is_wr),
        .st_offset  (addr[1:0]),
        .st_func3   (func3),
        .store_data (store_data),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .misalign   (lane_misalign),
        .illegal    (lane_illegal),
        .ld_offset  (off_q),
        .ld_func3   (func3_q),
        .rdata      (rdata_q),
        .load_data  (lane_load)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        is_load_d    = is_load_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        func3_d      = func3_q;
        off_d        = off_q;
        rdata_d      = rdata_q;
        stall        = 1'b0;
        misalign_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    if (lane_illegal || lane_misalign) begin
                        misalign_err = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        addr_d    = {addr[WIDTH-1:2], 2'b00};
                        off_d     = addr[1:0];
                        we_d      = is_wr;
                        is_load_d = is_rd;
                        be_d      = lane_be;
                        wdata_d   = lane_wdata;
                        func3_d   = func3;
                        err_d     = 1'b0;
                        cnt_d     = '0;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            is_load_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= 4'b0000;
            func3_q   <= 3'b000;
            off_q     <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            is_load_q <= is_load_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            func3_q   <= func3_d;
            off_q     <= off_d;
            rdata_q   <= rdata_d;
        end
    end

    assign mem_req    = (state_q == WAIT);
    assign mem_we     = (state_q == WAIT) && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_be     = be_q;
    assign bus_err    = (state_q == DONE) && err_q;
    assign load_valid = (state_q == DONE) && !err_q && is_load_q;
    assign load_data  = load_valid ? lane_load : '0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] store_data;
    logic             stall;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             misalign_err;
    logic             bus_err;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] last_ld;

    always #5 clk = ~clk;

    lsu_mem_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid        (valid),
        .opcode       (opcode),
        .func3        (func3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (arithmetic on access size) ----------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input bit st, input logic [2:0] f3);
        if (st) return (f3 <= 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input int off);
        int t;
        t = ((1 << size_of(f3)) - 1) << off;
        return 4'(t & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        longint v;
        case (size_of(f3))
            1:       v = longint'(sd & 32'hFF) * 64'h01010101;
            2:       v = longint'(sd & 32'hFFFF) * 64'h00010001;
            default: v = longint'(sd);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
        longint v;
        int     bits;
        bits = 8 * size_of(f3);
        v = (longint'(rd) >> (8 * off)) & ((longint'(1) << bits) - 1);
        if (!f3[2] && bits < 32 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    // One full transaction: issue, WAIT cycles with ack at wait-cycle ack_at
    // (>= TIMEOUT means never), DONE cycle, then one idle cycle.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input int ack_at,
                             input logic [31:0] rd, input bit drop_valid);
        bit bad;
        bit err;
        int nwait;
        int off;
        off = int'(a[1:0]);
        bad = !is_legal(st, f3);
        if (!bad) bad = (off % size_of(f3)) != 0;

        valid      = 1'b1;
        opcode     = st ? MEM_WR_OP : MEM_RD_OP;
        func3      = f3;
        addr       = a;
        store_data = sd;
        mem_ack    = 1'b0;
        #1;
        if (bad) begin
            chk("bad_misalign_err", misalign_err, 1);
            chk("bad_stall", stall, 0);
            chk("bad_req", mem_req, 0);
            tick();
            valid = 1'b0;
            #1;
            chk("bad_req_next", mem_req, 0);
            chk("bad_misalign_clear", misalign_err, 0);
            return;
        end
        chk("acc_stall", stall, 1);
        chk("acc_misalign", misalign_err, 0);
        chk("acc_req_c0", mem_req, 0);

        err   = (ack_at >= TIMEOUT);
        nwait = err ? TIMEOUT : ack_at + 1;
        for (int k = 0; k < nwait; k++) begin
            tick();
            if (drop_valid) valid = 1'b0;
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rd : $urandom;
            #1;
            chk("wait_req", mem_req, 1);
            chk("wait_stall", stall, 1);
            chk("wait_we", mem_we, st);
            chk("wait_addr", mem_addr, {a[31:2], 2'b00});
            chk("wait_be", mem_be, model_be(f3, off));
            if (st) chk("wait_wdata", mem_wdata, model_wdata(f3, sd));
            chk("wait_no_lv", load_valid, 0);
        end

        tick();
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        #1;
        chk("done_req", mem_req, 0);
        chk("done_stall", stall, 0);
        chk("done_bus_err", bus_err, err);
        chk("done_load_valid", load_valid, (!err && !st));
        chk("done_load_data", load_data, (!err && !st) ? model_load(f3, off, rd) : 32'h0);
        last_ld = load_data;

        tick();
        valid   = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("post_req", mem_req, 0);
        chk("post_stall", stall, 0);
        chk("post_lv", load_valid, 0);
        chk("post_bus_err", bus_err, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        valid      = 1'b0;
        opcode     = 7'd0;
        func3      = 3'd0;
        addr       = '0;
        store_data = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        last_ld    = '0;

        // Reset state
        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_lv", load_valid, 0);
        chk("rst_mis", misalign_err, 0);
        chk("rst_berr", bus_err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_ld", load_data, 0);
        rst_n = 1'b1;
        tick();

        // LW 0x100, ack at first WAIT cycle
        do_access(1'b0, F3_W, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        chk("lw_const", last_ld, 32'hDEADBEEF);
        // LB / LBU at 0x103
        do_access(1'b0, F3_B, 32'h103, 32'h0, 0, 32'h80FF0000, 1'b0);
        chk("lb_const", last_ld, 32'hFFFFFF80);
        do_access(1'b0, F3_BU, 32'h103, 32'h0, 2, 32'h80FF0000, 1'b0);
        chk("lbu_const", last_ld, 32'h00000080);
        // SH 0x202
        do_access(1'b1, F3_H, 32'h202, 32'h1234ABCD, 1, 32'h0, 1'b0);
        // Misaligned LW and illegal func3
        do_access(1'b0, F3_W, 32'h101, 32'h0, 0, 32'h0, 1'b0);
        do_access(1'b0, 3'b011, 32'h3, 32'h0, 0, 32'h0, 1'b0);
        // SW with no ack -> timeout, then back-to-back timeout on a load
        do_access(1'b1, F3_W, 32'h400, 32'hCAFEF00D, 1000, 32'h0, 1'b0);
        do_access(1'b0, F3_H, 32'h402, 32'h0, 1000, 32'h0, 1'b0);
        // Ack on the last permitted cycle wins; valid dropped during WAIT
        do_access(1'b0, F3_HU, 32'h52, 32'h0, TIMEOUT - 1, 32'h8001F00F, 1'b1);
        chk("lhu_late_ack", last_ld, 32'h00008001);

        // Non-memory opcode with stray ack in IDLE
        valid   = 1'b1;
        opcode  = 7'b0110011;
        addr    = 32'h101;
        mem_ack = 1'b1;
        #1;
        chk("nonmem_stall", stall, 0);
        chk("nonmem_mis", misalign_err, 0);
        tick();
        chk("nonmem_req", mem_req, 0);
        chk("nonmem_lv", load_valid, 0);
        valid   = 1'b0;
        mem_ack = 1'b0;

        // Reset asserted in WAIT
        valid  = 1'b1;
        opcode = MEM_RD_OP;
        func3  = F3_W;
        addr   = 32'h40;
        #1;
        tick();
        #1;
        chk("rstw_req_before", mem_req, 1);
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        chk("rstw_req", mem_req, 0);
        chk("rstw_stall", stall, 0);
        chk("rstw_addr", mem_addr, 0);
        tick();
        chk("rstw_lv", load_valid, 0);
        chk("rstw_berr", bus_err, 0);
        rst_n = 1'b1;
        tick();

        // Clean access after reset
        do_access(1'b0, F3_W, 32'h80, 32'h0, 0, 32'h13579BDF, 1'b0);
        chk("restart_ld", last_ld, 32'h13579BDF);

        // Randomized transactions against the reference model
        for (int i = 0; i < 60; i++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          dly;
            int          pick;
            st   = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            f3   = (pick < 8) ? (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)))
                              : 3'($urandom_range(0, 7));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0 && is_legal(st, f3))
                a[1:0] = 2'(size_of(f3) == 4 ? 0 : (size_of(f3) == 2 ? 2 * $urandom_range(0, 1)
                                                                       : $urandom_range(0, 3)));
            pick = $urandom_range(0, 9);
            dly  = (pick < 7) ? $urandom_range(0, 4) : (pick < 9 ? TIMEOUT - 1 : TIMEOUT + 5);
            do_access(st, f3, a, $urandom, dly, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
